// File: rtl/l1d_data_ram_arb_pkg.sv
// L1D shared types: RAM geometry, port payload structs and the data RAM
// arbiter FSM state.
package l1d_package;

  localparam int L1D_INDEX_W       = 6;
  localparam int L1D_WAY_NUM       = 4;
  localparam int L1D_WAY_W         = 2;
  localparam int L1D_OFFSET_W      = 1;
  localparam int L1D_TAG_W         = 20;
  localparam int DATA_RAM_DEPTH    = L1D_INDEX_W + L1D_WAY_W + L1D_OFFSET_W;
  localparam int REQ_DATA_WIDTH    = 32;
  localparam int REQ_DE_WIDTH      = REQ_DATA_WIDTH / 8;
  localparam int L1D_MSHR_ID_WIDTH = 3;
  localparam int SB_PLD_WIDTH      = 10;
  localparam int CREDIT_BUF_DEPTH  = 4;
  localparam int L1D_STARVE_LIMIT  = 8;

  typedef logic [SB_PLD_WIDTH-1:0] sb_payld;

  typedef struct packed {
    logic [L1D_INDEX_W-1:0]    index;
    logic [L1D_WAY_NUM-1:0]    way;
    logic [L1D_OFFSET_W-1:0]   offset;
    logic [REQ_DATA_WIDTH-1:0] wr_data;
    logic                      wr_last;
  } pack_l1d_data_pipe_downstream_rsp;

  typedef struct packed {
    logic [L1D_TAG_W-1:0]    tag;
    logic [L1D_INDEX_W-1:0]  index;
    logic [L1D_WAY_NUM-1:0]  way;
    logic [L1D_OFFSET_W-1:0] offset;
    logic                    rd_last;
  } pack_l1d_mshr_evict_req_pld;

  typedef struct packed {
    logic                      op_is_read;
    logic [L1D_INDEX_W-1:0]    index;
    logic [L1D_WAY_NUM-1:0]    way;
    logic [L1D_OFFSET_W-1:0]   offset;
    logic [REQ_DATA_WIDTH-1:0] wr_data;
    logic [REQ_DE_WIDTH-1:0]   wr_data_be;
    sb_payld                   sb_pld;
  } pack_l1d_mshr_rw_req_pld;

  typedef struct packed {
    logic [L1D_TAG_W-1:0]         tag;
    logic [L1D_INDEX_W-1:0]       index;
    logic [L1D_OFFSET_W-1:0]      offset;
    logic                         rd_last;
    logic [L1D_MSHR_ID_WIDTH-1:0] evict_id;
    logic [REQ_DATA_WIDTH-1:0]    wr_data;
  } pack_l1d_data_ram_evict_req;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LF_LOCK = 2'd1,
    EV_LOCK = 2'd2
  } l1d_arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LF   = 2'd1,
    GNT_EV   = 2'd2,
    GNT_RW   = 2'd3
  } l1d_arb_gnt_e;

  function automatic logic [L1D_WAY_W-1:0] way2bin(
    input logic [L1D_WAY_NUM-1:0] way
  );
    way2bin = '0;
    for (int i = 0; i < L1D_WAY_NUM; i++)
      if (way[i]) way2bin |= L1D_WAY_W'(i);
  endfunction

endpackage

// File: rtl/l1d_data_ram_arb_if.sv
// Request, RAM and response bundle of the L1D data RAM arbiter.
// master = requesters/RAM/credit buffer side, slave = arbiter.
interface l1d_data_ram_arb_if;
  import l1d_package::*;

  logic                             lf_vld;
  logic                             lf_rdy;
  pack_l1d_data_pipe_downstream_rsp lf_pld;

  logic                             ev_vld;
  logic                             ev_rdy;
  pack_l1d_mshr_evict_req_pld       ev_pld;
  logic [L1D_MSHR_ID_WIDTH-1:0]     ev_id;

  logic                             rw_vld;
  logic                             rw_rdy;
  pack_l1d_mshr_rw_req_pld          rw_pld;

  logic                             ram_en;
  logic                             ram_wr;
  logic [DATA_RAM_DEPTH-1:0]        ram_addr;
  logic [REQ_DATA_WIDTH-1:0]        ram_wdata;
  logic [REQ_DE_WIDTH-1:0]          ram_be;
  logic [REQ_DATA_WIDTH-1:0]        ram_rdata;

  logic                             rd_rsp_vld;
  logic [REQ_DATA_WIDTH-1:0]        rd_rsp_data;
  sb_payld                          rd_rsp_sb_pld;

  logic                             ev_out_vld;
  pack_l1d_data_ram_evict_req       ev_out_pld;
  logic                             ev_credit_ret;

  modport master (
    output lf_vld, lf_pld,
    output ev_vld, ev_pld, ev_id,
    output rw_vld, rw_pld,
    output ram_rdata, ev_credit_ret,
    input  lf_rdy, ev_rdy, rw_rdy,
    input  ram_en, ram_wr, ram_addr,
    input  ram_wdata, ram_be,
    input  rd_rsp_vld, rd_rsp_data,
    input  rd_rsp_sb_pld,
    input  ev_out_vld, ev_out_pld
  );

  modport slave (
    input  lf_vld, lf_pld,
    input  ev_vld, ev_pld, ev_id,
    input  rw_vld, rw_pld,
    input  ram_rdata, ev_credit_ret,
    output lf_rdy, ev_rdy, rw_rdy,
    output ram_en, ram_wr, ram_addr,
    output ram_wdata, ram_be,
    output rd_rsp_vld, rd_rsp_data,
    output rd_rsp_sb_pld,
    output ev_out_vld, ev_out_pld
  );

endinterface

// File: rtl/l1d_data_ram_arb_credit_cnt.sv
// Saturating credit counter for the evict output buffer.
// Loads INIT on reset; simultaneous inc/dec leaves the count unchanged.
module l1d_credit_cnt
  import l1d_package::*;
#(
  parameter int CREDIT_NUM = CREDIT_BUF_DEPTH,
  parameter int INIT       = CREDIT_NUM,
  localparam int CW        = $clog2(CREDIT_NUM + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          nonzero_o
);

  localparam logic [CW-1:0] MAX = CW'(CREDIT_NUM);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    unique case ({inc_i, dec_i})
      2'b10: if (count_q != MAX) count_d = count_q + 1'b1;
      2'b01: if (count_q != '0) count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= CW'(INIT);
    else     count_q <= count_d;
  end

  assign count_o   = count_q;
  assign nonzero_o = count_q != '0;

  // A return with every credit already home means the buffer lost track.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(inc_i && count_q == MAX)
  );

endmodule

// File: rtl/l1d_data_ram_arb.sv
// Single-port L1D data RAM arbiter: linefill writes, evict reads and hit
// read/writes, with burst locking, rw anti-starvation and evict credits.
module l1d_data_ram_arb
  import l1d_package::*;
#(
  parameter int STARVE_LIMIT = L1D_STARVE_LIMIT,
  parameter int CREDIT_NUM   = CREDIT_BUF_DEPTH
) (
  input logic               clk,
  input logic               rst,
  l1d_data_ram_arb_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(CREDIT_NUM + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  l1d_arb_state_e state_q;
  l1d_arb_state_e state_d;
  l1d_arb_gnt_e   gnt;

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          starve_hit;

  logic [CW-1:0] cred_cnt;
  logic          cred_nz;

  logic    rd_vld_q;
  logic    rd_vld_d;
  sb_payld rd_sb_q;
  sb_payld rd_sb_d;

  logic                       ev_vld_q;
  logic                       ev_vld_d;
  pack_l1d_data_ram_evict_req ev_q;
  pack_l1d_data_ram_evict_req ev_d;

  logic [L1D_INDEX_W-1:0]    sel_idx;
  logic [L1D_WAY_NUM-1:0]    sel_way;
  logic [L1D_OFFSET_W-1:0]   sel_off;
  logic                      sel_wr;
  logic [REQ_DATA_WIDTH-1:0] sel_wdata;
  logic [REQ_DE_WIDTH-1:0]   sel_be;

  assign starve_hit = starve_q == SLIM;

  l1d_credit_cnt #(
    .CREDIT_NUM (CREDIT_NUM)
  ) u_cred (
    .clk       (clk),
    .rst       (rst),
    .dec_i     (gnt == GNT_EV),
    .inc_i     (bus.ev_credit_ret),
    .count_o   (cred_cnt),
    .nonzero_o (cred_nz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (gnt)
      GNT_LF:  state_d = bus.lf_pld.wr_last ? IDLE : LF_LOCK;
      GNT_EV:  state_d = bus.ev_pld.rd_last ? IDLE : EV_LOCK;
      default: ;
    endcase
  end

  // Grant: a lock admits only its owner; in IDLE a starved rw wins first.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      unique case (state_q)
        LF_LOCK: if (bus.lf_vld) gnt = GNT_LF;
        EV_LOCK: if (bus.ev_vld && cred_nz) gnt = GNT_EV;
        default: begin
          if (bus.rw_vld && starve_hit)   gnt = GNT_RW;
          else if (bus.lf_vld)            gnt = GNT_LF;
          else if (bus.ev_vld && cred_nz) gnt = GNT_EV;
          else if (bus.rw_vld)            gnt = GNT_RW;
        end
      endcase
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_way   = '0;
    sel_off   = '0;
    sel_wr    = 1'b0;
    sel_wdata = '0;
    sel_be    = '0;
    unique case (gnt)
      GNT_LF: begin
        sel_idx   = bus.lf_pld.index;
        sel_way   = bus.lf_pld.way;
        sel_off   = bus.lf_pld.offset;
        sel_wr    = 1'b1;
        sel_wdata = bus.lf_pld.wr_data;
        sel_be    = '1;
      end
      GNT_EV: begin
        sel_idx = bus.ev_pld.index;
        sel_way = bus.ev_pld.way;
        sel_off = bus.ev_pld.offset;
      end
      GNT_RW: begin
        sel_idx = bus.rw_pld.index;
        sel_way = bus.rw_pld.way;
        sel_off = bus.rw_pld.offset;
        sel_wr  = !bus.rw_pld.op_is_read;
        if (!bus.rw_pld.op_is_read) begin
          sel_wdata = bus.rw_pld.wr_data;
          sel_be    = bus.rw_pld.wr_data_be;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.lf_rdy    = gnt == GNT_LF;
    bus.ev_rdy    = gnt == GNT_EV;
    bus.rw_rdy    = gnt == GNT_RW;
    bus.ram_en    = gnt != GNT_NONE;
    bus.ram_wr    = sel_wr;
    bus.ram_addr  = {sel_idx, way2bin(sel_way), sel_off};
    bus.ram_wdata = sel_wdata;
    bus.ram_be    = sel_be;
  end

  always_comb begin
    starve_d = '0;
    if (bus.rw_vld && gnt != GNT_RW)
      starve_d = starve_hit ? starve_q : starve_q + 1'b1;
  end

  always_comb begin
    rd_vld_d = (gnt == GNT_RW) && bus.rw_pld.op_is_read;
    rd_sb_d  = rd_vld_d ? bus.rw_pld.sb_pld : '0;
    ev_vld_d = gnt == GNT_EV;
    ev_d     = '0;
    if (ev_vld_d) begin
      ev_d.tag      = bus.ev_pld.tag;
      ev_d.index    = bus.ev_pld.index;
      ev_d.offset   = bus.ev_pld.offset;
      ev_d.rd_last  = bus.ev_pld.rd_last;
      ev_d.evict_id = bus.ev_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      rd_vld_q <= 1'b0;
      rd_sb_q  <= '0;
      ev_vld_q <= 1'b0;
      ev_q     <= '0;
    end else begin
      starve_q <= starve_d;
      rd_vld_q <= rd_vld_d;
      rd_sb_q  <= rd_sb_d;
      ev_vld_q <= ev_vld_d;
      ev_q     <= ev_d;
    end
  end

  // RAM read data lands one cycle after issue, alongside the registered valid.
  always_comb begin
    bus.rd_rsp_vld    = rd_vld_q;
    bus.rd_rsp_data   = rd_vld_q ? bus.ram_rdata : '0;
    bus.rd_rsp_sb_pld = rd_sb_q;
    bus.ev_out_vld    = ev_vld_q;
    bus.ev_out_pld    = ev_q;
    bus.ev_out_pld.wr_data = ev_vld_q ? bus.ram_rdata : '0;
  end

  a_way_onehot: assert property (
    @(posedge clk) disable iff (rst)
    (gnt != GNT_NONE) |-> $onehot(sel_way)
  );

endmodule

// File: tb/tb_l1d_data_ram_arb.sv
// Randomized + directed bench for l1d_data_ram_arb against a
// cycle-level behavioural model of grants, memory and credits.
module tb_l1d_data_ram_arb;
  import l1d_package::*;

  localparam int SL = 8;
  localparam int CN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1d_data_ram_arb_if bus();

  l1d_data_ram_arb #(
    .STARVE_LIMIT (SL),
    .CREDIT_NUM   (CN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [512];
  logic [31:0] mdl_mem [512];
  logic [31:0] ram_q;

  function automatic logic [31:0] bemask(input logic [3:0] be);
    for (int b = 0; b < 4; b++) bemask[8*b +: 8] = {8{be[b]}};
  endfunction

  initial for (int i = 0; i < 512; i++) begin
    ram[i]     <= 32'hA5000000 ^ (i * 32'h10101);
    mdl_mem[i]  = 32'hA5000000 ^ (i * 32'h10101);
  end

  always @(posedge clk)
    if (bus.ram_en) begin
      if (bus.ram_wr)
        ram[bus.ram_addr] <= (ram[bus.ram_addr] & ~bemask(bus.ram_be))
                           | (bus.ram_wdata & bemask(bus.ram_be));
      else
        ram_q <= ram[bus.ram_addr];
    end

  assign bus.ram_rdata = ram_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: lock owner 0 none / 1 lf / 2 ev
  int m_lock, m_starve, m_cred;
  bit m_rd_pend, m_ev_pend;
  logic [31:0] m_rd_data;
  sb_payld m_rd_sb;
  pack_l1d_data_ram_evict_req m_ev;

  bit o_lf, o_ev, o_rw, o_rd_vld;
  logic [8:0] o_addr;
  sb_payld o_rd_sb;

  function automatic void m_reset();
    m_lock = 0; m_starve = 0; m_cred = CN;
    m_rd_pend = 0; m_ev_pend = 0;
  endfunction

  function automatic int addr_of(int idx, logic [3:0] way, int off);
    int w = 0;
    for (int i = 0; i < 4; i++) if (way[i]) w = i;
    return idx * 8 + w * 2 + off;
  endfunction

  task automatic idle();
    bus.lf_vld = 0; bus.ev_vld = 0; bus.rw_vld = 0;
    bus.ev_credit_ret = 0;
  endtask

  task automatic step();
    int g, a;
    logic [31:0] wd;
    logic [3:0] be;
    bit wr;
    @(negedge clk);
    o_rd_vld = bus.rd_rsp_vld;
    o_rd_sb  = bus.rd_rsp_sb_pld;
    chk("rd_vld", bus.rd_rsp_vld, m_rd_pend);
    chk("rd_data", bus.rd_rsp_data, m_rd_pend ? m_rd_data : 32'd0);
    chk("rd_sb", bus.rd_rsp_sb_pld, m_rd_pend ? m_rd_sb : '0);
    chk("ev_vld", bus.ev_out_vld, m_ev_pend);
    chk("ev_pld", bus.ev_out_pld, m_ev_pend ? m_ev : '0);
    chk("cred", dut.cred_cnt, m_cred);
    g = 0;
    if (m_lock == 1) g = bus.lf_vld ? 1 : 0;
    else if (m_lock == 2) g = (bus.ev_vld && m_cred > 0) ? 2 : 0;
    else if (bus.rw_vld && m_starve >= SL) g = 3;
    else if (bus.lf_vld) g = 1;
    else if (bus.ev_vld && m_cred > 0) g = 2;
    else if (bus.rw_vld) g = 3;
    o_lf = bus.lf_vld && bus.lf_rdy;
    o_ev = bus.ev_vld && bus.ev_rdy;
    o_rw = bus.rw_vld && bus.rw_rdy;
    o_addr = bus.ram_addr;
    chk("rdy_onehot",
        $countones({bus.lf_rdy, bus.ev_rdy, bus.rw_rdy}) <= 1, 1);
    chk("lf_fire", o_lf, g == 1);
    chk("ev_fire", o_ev, g == 2);
    chk("rw_fire", o_rw, g == 3);
    chk("ram_en", bus.ram_en, g != 0);
    a = 0; wr = 0; wd = 0; be = 0;
    if (g == 1) begin
      a = addr_of(bus.lf_pld.index, bus.lf_pld.way, bus.lf_pld.offset);
      wr = 1; wd = bus.lf_pld.wr_data; be = 4'hF;
    end else if (g == 2) begin
      a = addr_of(bus.ev_pld.index, bus.ev_pld.way, bus.ev_pld.offset);
    end else if (g == 3) begin
      a = addr_of(bus.rw_pld.index, bus.rw_pld.way, bus.rw_pld.offset);
      wr = !bus.rw_pld.op_is_read;
      if (wr) begin wd = bus.rw_pld.wr_data; be = bus.rw_pld.wr_data_be; end
    end
    if (g != 0) begin
      chk("ram_addr", bus.ram_addr, a);
      chk("ram_wr", bus.ram_wr, wr);
      chk("ram_be", bus.ram_be, be);
      if (wr) chk("ram_wdata", bus.ram_wdata, wd);
    end
    m_rd_pend = (g == 3) && !wr;
    m_rd_data = mdl_mem[a];
    m_rd_sb   = bus.rw_pld.sb_pld;
    m_ev_pend = g == 2;
    m_ev = '0;
    m_ev.tag = bus.ev_pld.tag;
    m_ev.index = bus.ev_pld.index;
    m_ev.offset = bus.ev_pld.offset;
    m_ev.rd_last = bus.ev_pld.rd_last;
    m_ev.evict_id = bus.ev_id;
    m_ev.wr_data = mdl_mem[a];
    if (wr) mdl_mem[a] = (mdl_mem[a] & ~bemask(be)) | (wd & bemask(be));
    if (g == 1) m_lock = bus.lf_pld.wr_last ? 0 : 1;
    if (g == 2) m_lock = bus.ev_pld.rd_last ? 0 : 2;
    m_starve = (bus.rw_vld && g != 3) ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
    m_cred = m_cred + int'(bus.ev_credit_ret) - ((g == 2) ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    bus.lf_vld = $urandom_range(9) < 3;
    bus.lf_pld.index = 6'($urandom);
    bus.lf_pld.way = 4'b0001 << $urandom_range(3);
    bus.lf_pld.offset = 1'($urandom);
    bus.lf_pld.wr_data = $urandom;
    bus.lf_pld.wr_last = $urandom_range(2) == 0;
    bus.ev_vld = $urandom_range(9) < 3;
    bus.ev_pld.tag = 20'($urandom);
    bus.ev_pld.index = 6'($urandom);
    bus.ev_pld.way = 4'b0001 << $urandom_range(3);
    bus.ev_pld.offset = 1'($urandom);
    bus.ev_pld.rd_last = $urandom_range(2) == 0;
    bus.ev_id = 3'($urandom);
    bus.rw_vld = $urandom_range(9) < 4;
    bus.rw_pld.op_is_read = 1'($urandom);
    bus.rw_pld.index = 6'($urandom);
    bus.rw_pld.way = 4'b0001 << $urandom_range(3);
    bus.rw_pld.offset = 1'($urandom);
    bus.rw_pld.wr_data = $urandom;
    bus.rw_pld.wr_data_be = 4'($urandom);
    bus.rw_pld.sb_pld = 10'($urandom);
    bus.ev_credit_ret = (m_cred < CN) && ($urandom_range(1) == 1);
  endtask

  task automatic fill_credits();
    for (int k = 0; k < CN && m_cred < CN; k++) begin
      idle();
      bus.ev_credit_ret = 1;
      step();
    end
    idle();
  endtask

  initial begin
    drive_rand();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    bus.lf_vld = 1; bus.ev_vld = 1; bus.rw_vld = 1;
    #1;
    chk("rst_rdy", {bus.lf_rdy, bus.ev_rdy, bus.rw_rdy}, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_rd_vld", bus.rd_rsp_vld, 0);
    chk("rst_ev_vld", bus.ev_out_vld, 0);
    chk("rst_cred", dut.cred_cnt, CN);
    chk("rst_state", dut.state_q, IDLE);
    idle();
    @(posedge clk);
    #1;
    rst = 0;
    m_reset();

    // hit read address and registered response
    bus.rw_vld = 1;
    bus.rw_pld = '0;
    bus.rw_pld.op_is_read = 1;
    bus.rw_pld.index = 6'd3;
    bus.rw_pld.way = 4'b0100;
    bus.rw_pld.offset = 1'b1;
    bus.rw_pld.sb_pld = 10'h155;
    step();
    chk("hit_addr", o_addr, 9'b000011_10_1);
    idle();
    step();
    chk("hit_rsp_vld", o_rd_vld, 1);
    chk("hit_rsp_sb", o_rd_sb, 10'h155);

    // linefill burst locks out ev and rw
    bus.lf_vld = 1; bus.lf_pld.wr_last = 0;
    bus.ev_vld = 1; bus.ev_pld.rd_last = 1;
    bus.rw_vld = 1; bus.rw_pld.op_is_read = 0;
    step();
    chk("lf_lock_gnt", o_lf, 1);
    chk("lf_lock_state", dut.state_q, LF_LOCK);
    repeat (3) begin
      step();
      chk("lf_lock_hold", {o_ev, o_rw}, 0);
    end
    bus.lf_pld.wr_last = 1;
    step();
    chk("lf_unlock", dut.state_q, IDLE);
    bus.lf_vld = 0;
    step();
    idle();
    step();

    // starved rw wins on the ninth cycle
    fill_credits();
    step();
    for (int k = 1; k <= 9; k++) begin
      bus.rw_vld = 1; bus.rw_pld.op_is_read = 1;
      bus.ev_vld = 1; bus.ev_pld.rd_last = 1;
      bus.ev_credit_ret = m_cred < CN;
      step();
      chk("starve_rw_gnt", o_rw, k == 9);
    end
    chk("starve_clr", dut.starve_q, 0);
    idle();
    step();
    fill_credits();

    // reset in EV_LOCK with a read in flight
    bus.ev_vld = 1; bus.ev_pld.rd_last = 0;
    step();
    chk("ev_lock_state", dut.state_q, EV_LOCK);
    rst = 1;
    bus.lf_vld = 1; bus.rw_vld = 1;
    #1;
    chk("mid_rst_ev_vld", bus.ev_out_vld, 0);
    chk("mid_rst_cred", dut.cred_cnt, CN);
    chk("mid_rst_state", dut.state_q, IDLE);
    chk("mid_rst_rdy", {bus.lf_rdy, bus.ev_rdy, bus.rw_rdy, bus.ram_en}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    m_reset();
    idle();

    // credit exhaustion and return
    bus.ev_vld = 1; bus.ev_pld.rd_last = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("cred_issue", o_ev, k < 4);
    end
    bus.ev_credit_ret = 1;
    step();
    chk("cred_ret_cycle", o_ev, 0);
    bus.ev_credit_ret = 0;
    step();
    chk("cred_fifth", o_ev, 1);

    // simultaneous return and issue at count 2
    idle();
    bus.ev_credit_ret = 1;
    repeat (2) step();
    bus.ev_vld = 1;
    step();
    chk("cred_same_cycle", dut.cred_cnt, 2);
    idle();

    repeat (3000) begin
      drive_rand();
      step();
    end
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l1d_data_ram_arb.md
L1D_DATA_RAM_ARB -- requirements
Module: l1d_data_ram_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive rw-waiting cycles before rw is forced to top priority.
REQ-002 SHALL have parameter CREDIT_NUM, default CREDIT_BUF_DEPTH (4), meaning the evict-output credits held at reset.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports lf_vld in 1, lf_rdy out 1, lf_pld in pack_l1d_data_pipe_downstream_rsp: linefill write beats.
REQ-006 SHALL have ports ev_vld in 1, ev_rdy out 1, ev_pld in pack_l1d_mshr_evict_req_pld, ev_id in L1D_MSHR_ID_WIDTH: evict read beats.
REQ-007 SHALL have ports rw_vld in 1, rw_rdy out 1, rw_pld in pack_l1d_mshr_rw_req_pld: hit read/write requests.
REQ-008 SHALL have ports ram_en, ram_wr out 1; ram_addr out DATA_RAM_DEPTH; ram_wdata out REQ_DATA_WIDTH; ram_be out REQ_DE_WIDTH: single-port data RAM command.
REQ-009 SHALL have port ram_rdata  in  REQ_DATA_WIDTH  read data, valid 1 cycle after the read command.
REQ-010 SHALL have ports rd_rsp_vld out 1, rd_rsp_data out REQ_DATA_WIDTH, rd_rsp_sb_pld out sb_payld: rw read response, no backpressure.
REQ-011 SHALL have ports ev_out_vld out 1, ev_out_pld out pack_l1d_data_ram_evict_req, ev_credit_ret in 1: evict data to the credit buffer.

Function
REQ-012 SHALL accept a beat only when vld&&rdy; at most one rdy asserted per cycle; each accepted beat drives ram_en=1 that same cycle, combinationally.
REQ-013 SHALL form ram_addr = {index, binary(way one-hot), offset}; a non-one-hot way is an assertion error.
REQ-014 Linefill beat SHALL drive ram_wr=1, ram_wdata=wr_data, ram_be=all ones.
REQ-015 rw beat SHALL drive ram_wr=!op_is_read; on write ram_be=wr_data_be, ram_wdata=wr_data; on read ram_be=0.
REQ-016 Evict beat SHALL drive ram_wr=0; ev_rdy SHALL be 0 while credit count=0.
REQ-017 FSM states SHALL be IDLE, LF_LOCK, EV_LOCK.
REQ-018 In IDLE, priority SHALL be: rw if starve count=STARVE_LIMIT, then lf, then ev (credit>0), then rw.
REQ-019 An accepted lf beat with wr_last=0 in IDLE SHALL go to LF_LOCK; in LF_LOCK only lf is granted; a beat with wr_last=1 returns to IDLE.
REQ-020 An accepted ev beat with rd_last=0 in IDLE SHALL go to EV_LOCK; in EV_LOCK only ev is granted (credit permitting); rd_last=1 returns to IDLE.
REQ-021 A single beat with last=1 accepted in IDLE SHALL leave the FSM in IDLE.
REQ-022 Starve counter SHALL increment each cycle rw_vld=1 and rw not granted, saturating at STARVE_LIMIT, and clear on rw grant or rw_vld=0.
REQ-023 Read return SHALL be registered one cycle: rw read -> rd_rsp_vld=1 with rd_rsp_data=ram_rdata and rd_rsp_sb_pld from the request.
REQ-024 Evict read return SHALL be registered one cycle: ev_out_vld=1 with tag, index, offset, rd_last, evict_id=ev_id captured at issue and wr_data=ram_rdata.
REQ-025 Credit counter SHALL be 0..CREDIT_NUM: -1 on evict issue, +1 on ev_credit_ret, unchanged when both occur in one cycle.
REQ-026 ev_credit_ret while count=CREDIT_NUM SHALL saturate the counter and fire an assertion.
REQ-027 All rd_rsp_*/ev_out_* outputs SHALL be zero when their vld is 0.

Reset
REQ-028 On rst: FSM=IDLE, credit=CREDIT_NUM, starve=0, rd_rsp_vld=0, ev_out_vld=0, all registered payloads=0.
REQ-029 Reset mid-burst SHALL abandon the lock; an in-flight read return SHALL be dropped.
REQ-030 While rst=1 all rdy and ram_en SHALL be 0.

Structure
REQ-031 FSM state enum and STARVE_LIMIT default SHALL live in l1d_package; port payloads SHALL use existing package structs.
REQ-032 Credit counter SHALL be sub-module l1d_credit_cnt (init, dec, inc, count, nonzero).

Verification
REQ-033 lf(wr_last=0), ev, rw all valid in IDLE -> lf granted, FSM=LF_LOCK, ev/rw held until lf wr_last=1.
REQ-034 rw_vld held while ev back-to-back single beats -> rw granted on cycle 9 (STARVE_LIMIT=8), starve cleared.
REQ-035 Five evict beats, no credit return -> four issued, ev_rdy=0 next, one ev_credit_ret -> fifth issues next cycle.
REQ-036 rw read index=3, way=4'b0100, offset=1, sb_pld=0x155 -> ram_addr=9'b000011_10_1; next cycle rd_rsp_vld=1, rd_rsp_sb_pld=0x155.
REQ-037 Credit return and evict issue in the same cycle at count=2 -> count stays 2.
REQ-038 rst asserted in EV_LOCK with read in flight -> ev_out_vld=0 next cycle, credit=4, FSM=IDLE.
